aes_req_sched: RTL and testbench

//  Two-requester scheduler that shares one aes_cipher_top instance. Arbitrates

---
 rtl/aes_req_sched_if.sv | 56 +++++
 rtl/aes_req_sched.sv | 158 +++++++++++++++
 tb/tb_aes_req_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_req_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_req_sched_if
//  Brief    : Bundle of request, response and cipher-core signals used by
//             aes_req_sched. The slave modport is the scheduler's view, the
//             master modport is the surrounding environment (clients + core).
//  Revision : 1.0  initial release
// ============================================================================
interface aes_req_sched_if;
   // requester 0
   logic         req0_valid;
   logic         req0_ready;
   logic [127:0] req0_key;
   logic [127:0] req0_text;
   // requester 1
   logic         req1_valid;
   logic         req1_ready;
   logic [127:0] req1_key;
   logic [127:0] req1_text;
   // response
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [127:0] rsp_text;
   logic         rsp_err;
   logic [15:0]  jobs_done;
   // cipher core
   logic         core_ld;
   logic [127:0] core_key;
   logic [127:0] core_text_in;
   logic [127:0] core_text_out;
   logic         core_done;

   modport slave (
      input  req0_valid, req0_key, req0_text,
      output req0_ready,
      input  req1_valid, req1_key, req1_text,
      output req1_ready,
      input  rsp_ready,
      output rsp_valid, rsp_id, rsp_text, rsp_err, jobs_done,
      output core_ld, core_key, core_text_in,
      input  core_text_out, core_done
   );

   modport master (
      output req0_valid, req0_key, req0_text,
      input  req0_ready,
      output req1_valid, req1_key, req1_text,
      input  req1_ready,
      output rsp_ready,
      input  rsp_valid, rsp_id, rsp_text, rsp_err, jobs_done,
      input  core_ld, core_key, core_text_in,
      output core_text_out, core_done
   );
endinterface
`default_nettype wire

// File: rtl/aes_req_sched.sv
`default_nettype none
// ============================================================================
//  Module   : aes_req_sched
//  Brief    : Round-robin scheduler letting two requesters share one AES
//             cipher core. Accepts one job at a time, strobes the core, waits
//             for completion and returns the ciphertext tagged with the id.
//             Optional macro AES_SCHED_TIMEOUT_EN adds a BUSY watchdog that
//             aborts a job after TIMEOUT_CYC cycles with rsp_err=1.
//  Revision : 1.0  initial release
// ============================================================================
module aes_req_sched #(
   parameter int TIMEOUT_CYC = 32,
   parameter int CNT_W       = 6
) (
   input  wire logic      clk,
   input  wire logic      rst,
   aes_req_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t       r_state;
   logic         r_last_grant;
   logic         r_id;
   logic         r_core_ld;
   logic         r_rsp_valid;
   logic [127:0] r_core_key;
   logic [127:0] r_core_text;
   logic [127:0] r_rsp_text;
   logic [15:0]  r_jobs_done;

   logic         w_grant;
   logic         w_accept;
   logic [127:0] w_key;
   logic [127:0] w_text;
   logic         w_tmo;

   // The counter has to be able to reach TIMEOUT_CYC-1 without wrapping.
   if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC >= (1 << CNT_W))) begin : g_bad_cfg
      $error("aes_req_sched: CNT_W too narrow for TIMEOUT_CYC");
   end

   // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
      w_accept = (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
      w_key    = w_grant ? bus.req1_key  : bus.req0_key;
      w_text   = w_grant ? bus.req1_text : bus.req0_text;
   end

`ifdef AES_SCHED_TIMEOUT_EN
   localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_tmo_cnt;
   logic             r_rsp_err;

   assign w_tmo = (r_tmo_cnt == c_tmo_last);

   // Watchdog: cleared while the core is being loaded, counts BUSY cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_state == LOAD) begin
         r_tmo_cnt <= '0;
      end else if (r_state == BUSY) begin
         r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
   end

   // Error flag is decided on leaving BUSY; a same-cycle core_done wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_err <= 1'b0;
      end else if (r_state == BUSY) begin
         if (bus.core_done) begin
            r_rsp_err <= 1'b0;
         end else if (w_tmo) begin
            r_rsp_err <= 1'b1;
         end
      end
   end

   assign bus.rsp_err = r_rsp_err;
`else
   assign w_tmo       = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   // Job sequencer: accept, strobe the core, wait for done, hold the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_core_ld    <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_core_key   <= '0;
         r_core_text  <= '0;
         r_rsp_text   <= '0;
         r_jobs_done  <= '0;
      end else begin
         r_core_ld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_core_key   <= w_key;
                  r_core_text  <= w_text;
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
                  r_core_ld    <= 1'b1;
                  r_state      <= LOAD;
               end
            end
            LOAD: begin
               r_state <= BUSY;
            end
            BUSY: begin
               if (bus.core_done) begin
                  r_rsp_text  <= bus.core_text_out;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else if (w_tmo) begin
                  r_rsp_text  <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_jobs_done <= r_jobs_done + 16'd1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req0_ready   = w_accept & ~w_grant;
   assign bus.req1_ready   = w_accept &  w_grant;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_id       = r_id;
   assign bus.rsp_text     = r_rsp_text;
   assign bus.jobs_done    = r_jobs_done;
   assign bus.core_ld      = r_core_ld;
   assign bus.core_key     = r_core_key;
   assign bus.core_text_in = r_core_text;

endmodule
`default_nettype wire

// File: tb/tb_aes_req_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_req_sched
//  Brief    : Directed self-checking bench for aes_req_sched with a simple
//             cipher-core model (FIPS-197 vector known, other keys use a
//             stand-in transform since the scheduler only forwards data).
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_req_sched;

   localparam logic [127:0] c_fips_key = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] c_fips_pt  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] c_fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] c_k0 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] c_t0 = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
   localparam logic [127:0] c_k1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
   localparam logic [127:0] c_t1 = 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0;
   localparam logic [127:0] c_k2 = 128'h55555555_66666666_77777777_88888888;
   localparam logic [127:0] c_t2 = 128'h99999999_00000000_abababab_cdcdcdcd;
   localparam int           c_timeout = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   aes_req_sched_if bus ();

   aes_req_sched #(
      .TIMEOUT_CYC (c_timeout),
      .CNT_W       (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_vec  = 0;
   int   n_miss = 0;
   int   ld_cnt = 0;
   logic cm_en  = 1'b1;
   int   cm_lat = 2;
   logic cm_done;
   logic cm_busy;
   int   cm_cnt;
   logic spur_done = 1'b0;

   // Core stand-in: the real vector for FIPS input, a fixed scramble otherwise.
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
      if (k == c_fips_key && t == c_fips_pt) return c_fips_ct;
      return k ^ {t[63:0], t[127:64]};
   endfunction

   assign bus.core_text_out = core_fn(bus.core_key, bus.core_text_in);
   assign bus.core_done     = cm_done | spur_done;

   // Core timing model: done pulses cm_lat+2 cycles after the load strobe.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cm_busy <= 1'b0;
         cm_cnt  <= 0;
         cm_done <= 1'b0;
      end else begin
         cm_done <= 1'b0;
         if (bus.core_ld && cm_en) begin
            cm_busy <= 1'b1;
            cm_cnt  <= cm_lat;
         end else if (cm_busy) begin
            if (cm_cnt == 0) begin
               cm_done <= 1'b1;
               cm_busy <= 1'b0;
            end else begin
               cm_cnt <= cm_cnt - 1;
            end
         end
      end
   end

   // Count load strobes seen by the core.
   always @(posedge clk) begin
      if (bus.core_ld) ld_cnt <= ld_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rsp(input int max_cyc, output int cyc);
      cyc = 0;
      while (!bus.rsp_valid && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      if (!bus.rsp_valid) check_val("rsp_wait_timeout", 128'd0, 128'd1);
   endtask

   task automatic pop_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin : stim
      int           cyc;
      int           ld0;
      logic [127:0] held;
      bus.req0_valid = 1'b0; bus.req0_key = '0; bus.req0_text = '0;
      bus.req1_valid = 1'b0; bus.req1_key = '0; bus.req1_text = '0;
      bus.rsp_ready  = 1'b0;

      tick(3);
      rst = 1'b0;
      tick(1);

      // reset state
      check_val("rst_rsp_valid", bus.rsp_valid, 0);
      check_val("rst_core_ld",   bus.core_ld, 0);
      check_val("rst_jobs_done", bus.jobs_done, 0);
      check_val("rst_core_key",  bus.core_key, 0);
      check_val("rst_core_text", bus.core_text_in, 0);
      check_val("rst_rsp_text",  bus.rsp_text, 0);
      check_val("rst_rsp_id",    bus.rsp_id, 0);
      check_val("rst_rsp_err",   bus.rsp_err, 0);
      check_val("rst_ready",     {bus.req1_ready, bus.req0_ready}, 0);

      // FIPS-197 job on requester 0
      ld0 = ld_cnt;
      bus.req0_key = c_fips_key; bus.req0_text = c_fips_pt; bus.req0_valid = 1'b1;
      #1;
      check_val("fips_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
      tick(1);
      bus.req0_valid = 1'b0;
      check_val("fips_ld",       bus.core_ld, 1);
      check_val("fips_core_key", bus.core_key, c_fips_key);
      check_val("fips_core_txt", bus.core_text_in, c_fips_pt);
      wait_rsp(50, cyc);
      // LOAD at L, done in L+4, response in L+5
      check_val("fips_latency",  cyc, 5);
      check_val("fips_rsp_text", bus.rsp_text, c_fips_ct);
      check_val("fips_rsp_id",   bus.rsp_id, 0);
      check_val("fips_rsp_err",  bus.rsp_err, 0);
      check_val("fips_ld_pulses", ld_cnt - ld0, 1);
      pop_rsp();
      check_val("fips_rsp_drop", bus.rsp_valid, 0);
      check_val("fips_jobs",     bus.jobs_done, 1);

      // spurious core_done while IDLE
      ld0 = ld_cnt;
      spur_done = 1'b1;
      tick(1);
      spur_done = 1'b0;
      tick(2);
      check_val("spur_idle_valid", bus.rsp_valid, 0);
      check_val("spur_idle_ld",    ld_cnt - ld0, 0);
      check_val("spur_idle_jobs",  bus.jobs_done, 1);

      // fresh reset, then both requesters held valid: grants 0,1,0,1
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      check_val("rr_rst_jobs", bus.jobs_done, 0);
      bus.req0_key = c_k0; bus.req0_text = c_t0;
      bus.req1_key = c_k1; bus.req1_text = c_t1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      check_val("rr_first_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
      for (int j = 0; j < 4; j++) begin
         wait_rsp(50, cyc);
         check_val("rr_rsp_id", bus.rsp_id, j % 2);
         check_val("rr_rsp_text", bus.rsp_text,
                   (j % 2 == 0) ? core_fn(c_k0, c_t0) : core_fn(c_k1, c_t1));
         if (j == 1) begin
            held = bus.rsp_text;
            for (int k = 0; k < 5; k++) begin
               spur_done = (k == 2);
               tick(1);
               check_val("hold_valid", bus.rsp_valid, 1);
               check_val("hold_text",  bus.rsp_text, held);
               check_val("hold_id",    bus.rsp_id, 1);
               check_val("hold_ready", {bus.req1_ready, bus.req0_ready}, 0);
            end
            spur_done = 1'b0;
            check_val("hold_jobs", bus.jobs_done, 1);
         end
         pop_rsp();
         if (j == 3) begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
         end
         #1;
         check_val("rr_jobs", bus.jobs_done, j + 1);
         check_val("rr_idle_valid", bus.rsp_valid, 0);
         if (j < 3) begin
            check_val("rr_next_ready", {bus.req1_ready, bus.req0_ready},
                      (j % 2 == 0) ? 2'b10 : 2'b01);
         end
      end

      // reset while BUSY
      cm_lat = 20;
      bus.req0_key = c_k2; bus.req0_text = c_t2; bus.req0_valid = 1'b1;
      tick(1);
      bus.req0_valid = 1'b0;
      tick(2);
      check_val("mid_busy_key", bus.core_key, c_k2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("mid_rst_key",   bus.core_key, 0);
      check_val("mid_rst_text",  bus.core_text_in, 0);
      check_val("mid_rst_ld",    bus.core_ld, 0);
      check_val("mid_rst_valid", bus.rsp_valid, 0);
      check_val("mid_rst_jobs",  bus.jobs_done, 0);
      tick(1);
      rst = 1'b0;
      cm_lat = 2;
      tick(30);
      check_val("mid_no_rsp", bus.rsp_valid, 0);
      bus.req0_key = c_k1; bus.req0_text = c_t0; bus.req0_valid = 1'b1;
      tick(1);
      bus.req0_valid = 1'b0;
      wait_rsp(50, cyc);
      check_val("post_rst_text", bus.rsp_text, core_fn(c_k1, c_t0));
      check_val("post_rst_id",   bus.rsp_id, 0);
      pop_rsp();
      check_val("post_rst_jobs", bus.jobs_done, 1);

`ifdef AES_SCHED_TIMEOUT_EN
      // core never finishes: watchdog abort
      cm_en = 1'b0;
      bus.req0_key = c_k0; bus.req0_text = c_t0; bus.req0_valid = 1'b1;
      tick(1);
      bus.req0_valid = 1'b0;
      check_val("tmo_ld", bus.core_ld, 1);
      wait_rsp(100, cyc);
      // BUSY entered one cycle after LOAD, response TIMEOUT_CYC cycles later
      check_val("tmo_latency", cyc, c_timeout + 1);
      check_val("tmo_err",     bus.rsp_err, 1);
      check_val("tmo_text",    bus.rsp_text, 0);
      pop_rsp();
      check_val("tmo_jobs", bus.jobs_done, 2);
      cm_en = 1'b1;
      bus.req1_key = c_k1; bus.req1_text = c_t1; bus.req1_valid = 1'b1;
      tick(1);
      bus.req1_valid = 1'b0;
      wait_rsp(50, cyc);
      check_val("tmo_after_err",  bus.rsp_err, 0);
      check_val("tmo_after_text", bus.rsp_text, core_fn(c_k1, c_t1));
      check_val("tmo_after_id",   bus.rsp_id, 1);
      pop_rsp();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
